capture_sequencer: RTL and testbench

Sequences one logic-capture run around the capture core and owns the sample buffer. It arms the core with a `start` pulse and forwards host aborts. It manages the circular write pointer into a single-port-write/single-port-read sample RAM and asserts `pageFull` when the post-trigger region would overwrite retained data. After the run it streams the retained trace, oldest first, over a valid/ready port. It sits between the host command registers, the capture core (`samplePacket`/`write_enable`/`idle`/`postTrigger`) and the sample RAM.

---
 rtl/capture_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_capture_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_sequencer.sv
// capture_sequencer: run control for the capture core, circular write pointer into
// the sample RAM, and oldest-first readout of the retained trace over valid/ready.
module capture_sequencer #(
    parameter int ADDR_WIDTH          = 12,
    parameter int SAMPLE_PACKET_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cmd_arm,
    input  logic                           cmd_abort,
    input  logic                           cmd_read,
    input  logic                           cap_idle,
    input  logic                           cap_post_trigger,
    input  logic                           cap_write_enable,
    input  logic [SAMPLE_PACKET_WIDTH-1:0] cap_sample_packet,
    output logic                           cap_start,
    output logic                           cap_abort,
    output logic                           cap_page_full,
    output logic                           mem_wr_en,
    output logic [ADDR_WIDTH-1:0]          mem_wr_addr,
    output logic [SAMPLE_PACKET_WIDTH-1:0] mem_wr_data,
    output logic                           mem_rd_en,
    output logic [ADDR_WIDTH-1:0]          mem_rd_addr,
    input  logic [SAMPLE_PACKET_WIDTH-1:0] mem_rd_data,
    output logic                           rd_valid,
    output logic                           rd_last,
    output logic [SAMPLE_PACKET_WIDTH-1:0] rd_data,
    input  logic                           rd_ready,
    output logic                           busy,
    output logic                           done,
    output logic                           aborted,
    output logic                           overflow,
    output logic [ADDR_WIDTH:0]            fill,
    output logic [ADDR_WIDTH-1:0]          begin_addr,
    output logic [ADDR_WIDTH-1:0]          trig_addr
);

    localparam logic [ADDR_WIDTH:0] FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_CAPTURE,
        S_DONE,
        S_READOUT
    } state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic                  trig_seen;

    // Readout pipeline: issued-read counter, one in-flight RAM read, two-entry buffer.
    logic [ADDR_WIDTH:0]            rd_issued;
    logic [ADDR_WIDTH-1:0]          rd_addr;
    logic                           rd_pending;
    logic                           rd_pending_last;
    logic [1:0]                     buf_count;
    logic                           buf_head;
    logic                           buf_tail;
    logic [SAMPLE_PACKET_WIDTH-1:0] buf_data [2];
    logic [1:0]                     buf_last;

    logic       in_capture;
    logic       buf_is_full;
    logic       wr_accept;
    logic       start_run;
    logic       start_read;
    logic       abort_run;
    logic       abort_read;
    logic       pop;
    logic [2:0] occupancy;

    assign in_capture  = (state == S_WAIT_BUSY) || (state == S_CAPTURE);
    assign buf_is_full = (fill == FULL);
    assign abort_run   = cmd_abort && ((state == S_START) || in_capture);
    assign abort_read  = cmd_abort && (state == S_READOUT);
    assign start_run   = ((state == S_IDLE) || (state == S_DONE)) && cmd_arm && !cmd_abort;
    assign start_read  = (state == S_DONE) && cmd_read && !cmd_arm && !cmd_abort
                         && (fill != '0);

    assign cap_page_full = in_capture && cap_post_trigger && buf_is_full;
    assign wr_accept     = in_capture && cap_write_enable && !cap_page_full;
    assign mem_wr_en     = wr_accept;
    assign mem_wr_addr   = wr_ptr;
    assign mem_wr_data   = cap_sample_packet;

    assign rd_valid  = (buf_count != 2'd0);
    assign rd_data   = rd_valid ? buf_data[buf_head] : '0;
    assign rd_last   = rd_valid && buf_last[buf_head];
    assign pop       = rd_valid && rd_ready;
    // A word leaving this cycle frees its slot in time for a read issued now.
    assign occupancy = {1'b0, buf_count} + {2'b0, rd_pending} - {2'b0, pop};
    assign mem_rd_en = (state == S_READOUT) && !cmd_abort && (rd_issued != fill)
                       && (occupancy < 3'd2);
    assign mem_rd_addr = rd_addr;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // NOTE: every signal assigned in this block gets its default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        cap_start  = 1'b0;
        cap_abort  = abort_run;
        busy       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_run) state_next = S_START;
            end
            S_START: begin
                cap_start  = 1'b1;
                busy       = 1'b1;
                state_next = cmd_abort ? S_DONE : S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                busy = 1'b1;
                if (cmd_abort)     state_next = S_DONE;
                else if (!cap_idle) state_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                busy = 1'b1;
                if (cmd_abort || cap_idle) state_next = S_DONE;
            end
            S_DONE: begin
                if (start_run)       state_next = S_START;
                else if (start_read) state_next = S_READOUT;
            end
            S_READOUT: begin
                busy = 1'b1;
                if (cmd_abort || (pop && buf_last[buf_head])) state_next = S_DONE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr          <= '0;
            fill            <= '0;
            begin_addr      <= '0;
            trig_addr       <= '0;
            trig_seen       <= 1'b0;
            done            <= 1'b0;
            aborted         <= 1'b0;
            overflow        <= 1'b0;
            rd_issued       <= '0;
            rd_addr         <= '0;
            rd_pending      <= 1'b0;
            rd_pending_last <= 1'b0;
            buf_count       <= 2'd0;
            buf_head        <= 1'b0;
            buf_tail        <= 1'b0;
        end else begin
            if (start_run) begin
                wr_ptr     <= '0;
                fill       <= '0;
                begin_addr <= '0;
                trig_addr  <= '0;
                trig_seen  <= 1'b0;
                done       <= 1'b0;
                aborted    <= 1'b0;
                overflow   <= 1'b0;
            end
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (!buf_is_full) fill <= fill + 1'b1;
                else              begin_addr <= begin_addr + 1'b1;
                if (cap_post_trigger && !trig_seen) begin
                    trig_addr <= wr_ptr;
                    trig_seen <= 1'b1;
                end
            end
            if (cap_page_full && cap_write_enable) overflow <= 1'b1;
            if ((state == S_CAPTURE) && cap_idle && !cmd_abort) done <= 1'b1;
            if (abort_run || abort_read) aborted <= 1'b1;

            if (start_read) begin
                rd_addr    <= begin_addr;
                rd_issued  <= '0;
                rd_pending <= 1'b0;
                buf_count  <= 2'd0;
                buf_head   <= 1'b0;
                buf_tail   <= 1'b0;
            end else if (abort_read) begin
                rd_pending <= 1'b0;
                buf_count  <= 2'd0;
                buf_head   <= 1'b0;
                buf_tail   <= 1'b0;
            end else if (state == S_READOUT) begin
                rd_pending      <= mem_rd_en;
                rd_pending_last <= (rd_issued == fill - 1'b1);
                if (mem_rd_en) begin
                    rd_addr   <= rd_addr + 1'b1;
                    rd_issued <= rd_issued + 1'b1;
                end
                if (pop)        buf_head <= ~buf_head;
                if (rd_pending) buf_tail <= ~buf_tail;
                buf_count <= buf_count + {1'b0, rd_pending} - {1'b0, pop};
            end
        end
    end

    // NOTE: buffer storage has no reset; rd_data/rd_last are gated by rd_valid instead.
    always_ff @(posedge clk) begin
        if (rd_pending) begin
            buf_data[buf_tail] <= mem_rd_data;
            buf_last[buf_tail] <= rd_pending_last;
        end
    end

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer with a 16-entry sample RAM model.
module tb_capture_sequencer;

    localparam int AW = 4;
    localparam int PW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_arm, cmd_abort, cmd_read;
    logic          cap_idle, cap_post_trigger, cap_write_enable;
    logic [PW-1:0] cap_sample_packet;
    logic          cap_start, cap_abort, cap_page_full;
    logic          mem_wr_en, mem_rd_en;
    logic [AW-1:0] mem_wr_addr, mem_rd_addr;
    logic [PW-1:0] mem_wr_data, mem_rd_data;
    logic          rd_valid, rd_last, rd_ready;
    logic [PW-1:0] rd_data;
    logic          busy, done, aborted, overflow;
    logic [AW:0]   fill;
    logic [AW-1:0] begin_addr, trig_addr;

    int n_checks = 0;
    int n_pass   = 0;

    logic [PW-1:0] ram [16];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
    end

    capture_sequencer #(.ADDR_WIDTH(AW), .SAMPLE_PACKET_WIDTH(PW)) dut (
        .clk(clk), .reset(reset),
        .cmd_arm(cmd_arm), .cmd_abort(cmd_abort), .cmd_read(cmd_read),
        .cap_idle(cap_idle), .cap_post_trigger(cap_post_trigger),
        .cap_write_enable(cap_write_enable), .cap_sample_packet(cap_sample_packet),
        .cap_start(cap_start), .cap_abort(cap_abort), .cap_page_full(cap_page_full),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .rd_valid(rd_valid), .rd_last(rd_last), .rd_data(rd_data), .rd_ready(rd_ready),
        .busy(busy), .done(done), .aborted(aborted), .overflow(overflow),
        .fill(fill), .begin_addr(begin_addr), .trig_addr(trig_addr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [PW-1:0] pkt, input logic post);
        cap_write_enable  = 1'b1;
        cap_sample_packet = pkt;
        cap_post_trigger  = post;
        tick();
        cap_write_enable  = 1'b0;
    endtask

    task automatic arm();
        cmd_arm = 1'b1;
        tick();
        cmd_arm  = 1'b0;
        cap_idle = 1'b0;
    endtask

    // Read the whole trace; expected words are first, first+1, ... with rd_last on the n-th.
    task automatic readout(input logic [PW-1:0] first, input int n, input bit stall);
        int k = 0;
        int cyc = 0;
        int first_cyc = -1;
        bit was_stalled = 1'b0;
        logic [PW-1:0] held = '0;
        cmd_read = 1'b1;
        tick();
        cmd_read = 1'b0;
        while (k < n && cyc < 200) begin
            rd_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            #1;
            if (rd_valid && first_cyc < 0) first_cyc = cyc;
            if (was_stalled) check("stall_hold", {rd_valid, rd_data}, {1'b1, held});
            was_stalled = rd_valid && !rd_ready;
            held = rd_data;
            if (rd_valid && rd_ready) begin
                check("rd_data", rd_data, first + k);
                check("rd_last", rd_last, (k == n - 1));
                k++;
            end
            tick();
            cyc++;
        end
        rd_ready = 1'b0;
        check("rd_words", k, n);
        check("rd_first_valid_cycle", first_cyc, 2);
        if (!stall) check("rd_cycles", cyc, n + 2);
        #1;
        check("rd_back_to_done", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        cmd_arm = 1'b0; cmd_abort = 1'b0; cmd_read = 1'b0;
        cap_idle = 1'b1; cap_post_trigger = 1'b0; cap_write_enable = 1'b0;
        cap_sample_packet = '0; rd_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("reset_flags", {busy, done, aborted, overflow, cap_start, cap_abort,
                              cap_page_full, mem_wr_en, mem_rd_en, rd_valid}, '0);
        check("reset_ptrs", {fill, begin_addr, trig_addr, mem_wr_addr}, '0);

        // 5 pre + 6 post writes, normal completion
        arm();
        #1;
        check("cap_start_pulse", cap_start, 1'b1);
        tick();
        check("cap_start_once", cap_start, 1'b0);
        cap_write_enable = 1'b1; cap_sample_packet = 32'd1; cap_post_trigger = 1'b0;
        #1;
        check("wr_passthrough", {mem_wr_en, mem_wr_addr, mem_wr_data}, {1'b1, 4'd0, 32'd1});
        tick();
        cap_write_enable = 1'b0;
        for (int i = 2; i <= 5; i++) wr(i, 1'b0);
        for (int i = 6; i <= 11; i++) wr(i, 1'b1);
        cap_idle = 1'b1;
        tick();
        check("a_fill", fill, 11);
        check("a_begin", begin_addr, 0);
        check("a_trig", trig_addr, 5);
        check("a_done_busy", {done, busy, overflow}, 3'b100);
        readout(32'd1, 11, 1'b0);
        readout(32'd1, 11, 1'b1);

        // 20 pre-trigger writes wrap the buffer, then a post-trigger write is dropped
        arm();
        #1;
        check("b_arm_clears", {fill, done}, '0);
        tick();
        for (int i = 1; i <= 20; i++) wr(i, 1'b0);
        check("b_fill", fill, 16);
        check("b_begin", begin_addr, 4);
        check("b_no_page_full_pre", cap_page_full, 1'b0);
        cap_write_enable = 1'b1; cap_sample_packet = 32'd21; cap_post_trigger = 1'b1;
        #1;
        check("b_page_full", {cap_page_full, mem_wr_en}, 2'b10);
        tick();
        cap_write_enable = 1'b0;
        check("b_overflow", {overflow, fill, begin_addr, trig_addr}, {1'b1, 5'd16, 4'd4, 4'd0});
        cap_idle = 1'b1;
        tick();
        check("b_done", done, 1'b1);
        readout(32'd5, 16, 1'b0);

        // fill reaches DEPTH on the first post write; page_full follows; then abort in CAPTURE
        arm();
        tick();
        for (int i = 1; i <= 15; i++) wr(i, 1'b0);
        cap_write_enable = 1'b1; cap_sample_packet = 32'd16; cap_post_trigger = 1'b1;
        #1;
        check("c_not_full_yet", cap_page_full, 1'b0);
        tick();
        cap_write_enable = 1'b0;
        check("c_full_after", {cap_page_full, trig_addr}, {1'b1, 4'd15});
        cap_write_enable = 1'b1; cap_sample_packet = 32'd17;
        #1;
        check("c_drop", mem_wr_en, 1'b0);
        tick();
        cap_write_enable = 1'b0;
        check("c_overflow", {overflow, fill, begin_addr}, {1'b1, 5'd16, 4'd0});
        cmd_abort = 1'b1;
        #1;
        check("d_cap_abort", cap_abort, 1'b1);
        tick();
        cmd_abort = 1'b0;
        #1;
        check("d_after_abort", {cap_abort, aborted, done, busy, cap_page_full}, 5'b01000);
        cap_idle = 1'b1;
        readout(32'd1, 16, 1'b1);

        // abort in the middle of a readout, then a full repeat
        rd_ready = 1'b1;
        cmd_read = 1'b1;
        tick();
        cmd_read = 1'b0;
        tick();
        tick();
        tick();
        check("e_valid_before_abort", rd_valid, 1'b1);
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        rd_ready = 1'b0;
        #1;
        check("e_flushed", {rd_valid, busy, aborted}, 3'b001);
        readout(32'd1, 16, 1'b0);

        // arm+abort together in IDLE; read with an empty buffer is ignored
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cmd_arm = 1'b1; cmd_abort = 1'b1;
        tick();
        cmd_arm = 1'b0; cmd_abort = 1'b0;
        #1;
        check("f_no_start", {cap_start, busy}, 2'b00);
        arm();
        cmd_abort = 1'b1;
        #1;
        check("f_abort_in_start", cap_abort, 1'b1);
        tick();
        cmd_abort = 1'b0;
        cmd_read = 1'b1;
        tick();
        cmd_read = 1'b0;
        #1;
        check("f_empty_read_ignored", {busy, mem_rd_en, aborted}, 3'b001);

        // reset during CAPTURE
        arm();
        tick();
        wr(1, 1'b0); wr(2, 1'b0); wr(3, 1'b0); wr(4, 1'b1);
        check("g_capturing", {busy, trig_addr, fill}, {1'b1, 4'd3, 5'd4});
        cap_write_enable = 1'b1; cap_sample_packet = '0; cap_post_trigger = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("g_reset_flags", {busy, done, aborted, overflow, cap_start, cap_abort,
                                cap_page_full, mem_wr_en, mem_rd_en, rd_valid, rd_last}, '0);
        check("g_reset_ptrs", {fill, begin_addr, trig_addr, mem_wr_addr, mem_rd_addr}, '0);
        check("g_reset_rd_data", rd_data, '0);
        cap_write_enable = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
